// File: rtl/alu_exec_ctrl.sv
// Runs one data-processing instruction at a time through the shared ALU, owns NZCV, retires to writeback.
// Build option COND_EXEC_EN: evaluate the condition field; without it every instruction executes as AL.
module alu_exec_ctrl #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic          in_s,
  input  logic [3:0]    in_cond,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_shift_cout,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic          alu_s,
  output logic          alu_c,
  output logic          alu_v,
  output logic          alu_shift_cout,
  input  logic [DW-1:0] alu_f,
  input  logic [3:0]    alu_nzcv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_we,
  output logic [RW-1:0] out_rd,
  output logic [DW-1:0] out_data,
  output logic [3:0]    flags,
  input  logic          flags_wr_en,
  input  logic [3:0]    flags_wr_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic       accept, wb_done, pass, is_test, flag_upd;

  assign in_ready  = (state == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == WB);
  assign wb_done   = out_valid & out_ready;
  assign alu_c     = flags[1];
  assign alu_v     = flags[0];
  // TST/TEQ/CMP/CMN only produce flags and never write a register
  assign is_test   = (op_q[3:2] == 2'b10);
  assign flag_upd  = (state == EXEC) & pass & (alu_s | is_test);

  function automatic logic [3:0] map_op(input logic [3:0] op);
    case (op)
      4'h8:    map_op = 4'h0;
      4'h9:    map_op = 4'h1;
      4'hA:    map_op = 4'h2;
      4'hB:    map_op = 4'h4;
      default: map_op = op;
    endcase
  endfunction

`ifdef COND_EXEC_EN
  logic [3:0] cond_q;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst)         cond_q <= '0;
    else if (accept) cond_q <= in_cond;
  end

  // Pre-update flags: the register only changes at the EXEC->WB edge
  assign pass = cond_pass(cond_q, flags);
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign pass        = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_s          <= 1'b0;
      alu_shift_cout <= 1'b0;
      op_q           <= '0;
      out_rd         <= '0;
    end else if (accept) begin
      alu_a          <= in_a;
      alu_b          <= in_b;
      alu_op         <= map_op(in_opcode);
      alu_s          <= in_s;
      alu_shift_cout <= in_shift_cout;
      op_q           <= in_opcode;
      out_rd         <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_we   <= 1'b0;
    end else if (state == EXEC) begin
      out_data <= alu_f;
      out_we   <= pass & ~is_test;
    end else if (wb_done) begin
      out_we   <= 1'b0;
    end
  end

  // Instruction flag result takes priority over a coincident MSR write
  always_ff @(posedge clk) begin
    if (rst)              flags <= '0;
    else if (flag_upd)    flags <= alu_nzcv;
    else if (flags_wr_en) flags <= flags_wr_data;
  end

endmodule
